mascota_necesidades_n: RTL and testbench

- Parametrised need/mood engine for the virtual-pet design.
- Successor to the fixed food/medicine/mood/rest state machine: N independent need channels, each a saturating level counter.
- Each level decays on a programmable period, is refilled by debounced button pulses, and recovers while a sensor condition (photocell, ultrasound) holds.
- A global state machine derives pet status. Test mode accelerates time. Sits between the input conditioning/debounce blocks and the display (sseg/an) driver.

---
 rtl/mascota_necesidades_n_pkg.sv | 19 +
 rtl/mascota_necesidades_n_need_channel.sv | 50 +++++
 rtl/mascota_necesidades_n.sv | 162 ++++++++++++++++
 tb/tb_mascota_necesidades_n.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mascota_necesidades_n_pkg.sv
// Shared status encoding and elaboration helpers for the pet need/mood engine.
package mascota_necesidades_n_pkg;

    typedef enum logic [2:0] {
        EST_NORMAL  = 3'd0,
        EST_ALERTA  = 3'd1,
        EST_CRITICO = 3'd2,
        EST_MUERTO  = 3'd3
    } estado_t;

    function automatic int max1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/mascota_necesidades_n_need_channel.sv
// One need channel: saturating level register refilled by events, decayed or recovered per period.
// Level updates one cycle after the triggering event; i_en low freezes the level.
module need_channel #(
    parameter int LVL_W   = 3,
    parameter int LVL_MAX = 5,
    parameter int INC     = 2
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic             i_evt,
    input  logic             i_pulse,
    input  logic             i_cond,
    output logic [LVL_W-1:0] o_lvl
);
    localparam int S_W = LVL_W + 2;
    localparam logic signed [S_W-1:0] INC_S = S_W'(INC);
    localparam logic signed [S_W-1:0] ONE_S = S_W'(1);
    localparam logic signed [S_W-1:0] MAX_S = S_W'(LVL_MAX);
    localparam logic [LVL_W-1:0]      MAX_V = LVL_W'(LVL_MAX);

    logic [LVL_W-1:0]        r_lvl;
    logic signed [S_W-1:0]   w_evt_d;
    logic signed [S_W-1:0]   w_per_d;
    logic signed [S_W-1:0]   w_sum;
    logic [LVL_W-1:0]        w_next;

    always_comb begin
        w_evt_d = i_evt ? INC_S : '0;
        w_per_d = i_pulse ? (i_cond ? ONE_S : -ONE_S) : '0;
        w_sum   = $signed({2'b00, r_lvl}) + w_evt_d + w_per_d;
        // event and decay net together before saturating
        if (w_sum[S_W-1])
            w_next = '0;
        else if (w_sum > MAX_S)
            w_next = MAX_V;
        else
            w_next = w_sum[LVL_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (i_reset)
            r_lvl <= MAX_V;
        else if (i_en)
            r_lvl <= w_next;
    end

    assign o_lvl = r_lvl;

endmodule

// File: rtl/mascota_necesidades_n.sv
// Need/mood engine: N_CH decaying need levels, period prescaler, death counter and status FSM.
// Levels lag inputs by 1 cycle, status by 2; no backpressure, inputs are sampled every cycle.
module mascota_necesidades_n
    import mascota_necesidades_n_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int LVL_W         = 3,
    parameter int LVL_MAX       = 5,
    parameter int LOW_TH        = 1,
    parameter int TICK_DIV      = 50000000,
    parameter int DECAY_TICKS   = 10,
    parameter int TEST_DIV      = 10,
    parameter int INC           = 2,
    parameter int DEATH_PERIODS = 3
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  test_mode,
    input  logic [N_CH-1:0]                       evt_in,
    input  logic [N_CH-1:0]                       cond_in,
    output logic [N_CH*LVL_W-1:0]                 levels,
    output logic [N_CH-1:0]                       alert_mask,
    output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] worst_ch,
    output logic [2:0]                            estado,
    output logic                                  period_pulse
);
    localparam int WC_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int PRE_W = clog2_min1(TICK_DIV);
    localparam int PER_W = clog2_min1(DECAY_TICKS + 1);
    localparam int DTH_W = clog2_min1(DEATH_PERIODS + 1);

    localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(TICK_DIV - 1);
    localparam logic [PER_W:0]   PER_NORM_V = (PER_W+1)'(max1(DECAY_TICKS));
    localparam logic [PER_W:0]   PER_TEST_V = (PER_W+1)'(max1(DECAY_TICKS / TEST_DIV));
    localparam logic [DTH_W-1:0] DTH_MAX    = DTH_W'(DEATH_PERIODS);
    localparam logic [LVL_W-1:0] LOW_V      = LVL_W'(LOW_TH);

    logic [PRE_W-1:0] r_pre;
    logic [PER_W-1:0] r_per;
    logic             r_pulse;
    logic [DTH_W-1:0] r_dth;
    estado_t          r_est;
    estado_t          w_est_nxt;

    logic [PER_W:0]   w_period;
    logic [PER_W:0]   w_per_inc;
    logic             w_tick;
    logic             w_per_done;
    logic             w_alive;
    logic             w_any_zero;
    logic             w_any_alert;
    logic [N_CH-1:0]  w_zero;
    logic [LVL_W-1:0] w_lvl [N_CH];
    logic [LVL_W-1:0] w_min;
    logic [WC_W-1:0]  w_worst;

    // >= lets a switch to the shorter test period fire on the very next tick
    assign w_period   = test_mode ? PER_TEST_V : PER_NORM_V;
    assign w_per_inc  = {1'b0, r_per} + (PER_W+1)'(1);
    assign w_tick     = (r_pre == PRE_LAST);
    assign w_per_done = w_tick && (w_per_inc >= w_period);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pre   <= '0;
            r_per   <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_pre   <= w_tick ? '0 : r_pre + PRE_W'(1);
            r_pulse <= w_per_done;
            if (w_per_done)
                r_per <= '0;
            else if (w_tick)
                r_per <= w_per_inc[PER_W-1:0];
        end
    end

    assign w_alive = (r_est != EST_MUERTO);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        need_channel #(
            .LVL_W   (LVL_W),
            .LVL_MAX (LVL_MAX),
            .INC     (INC)
        ) u_ch (
            .clk     (clk),
            .i_reset (reset),
            .i_en    (w_alive),
            .i_evt   (evt_in[g]),
            .i_pulse (r_pulse),
            .i_cond  (cond_in[g]),
            .o_lvl   (w_lvl[g])
        );
        assign levels[g*LVL_W +: LVL_W] = w_lvl[g];
        assign alert_mask[g]            = (w_lvl[g] <= LOW_V);
        assign w_zero[g]                = (w_lvl[g] == '0);
    end

    assign w_any_zero  = |w_zero;
    assign w_any_alert = |alert_mask;

    always_comb begin
        w_min   = w_lvl[0];
        w_worst = '0;
        for (int i = 1; i < N_CH; i++) begin
            if (w_lvl[i] < w_min) begin
                w_min   = w_lvl[i];
                w_worst = WC_W'(i);
            end
        end
    end

    assign worst_ch = w_worst;

    always_ff @(posedge clk) begin
        if (reset)
            r_dth <= '0;
        else if (!w_any_zero)
            r_dth <= '0;
        else if (r_pulse && (r_dth != DTH_MAX))
            r_dth <= r_dth + DTH_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_est <= EST_NORMAL;
        else
            r_est <= w_est_nxt;
    end

    always_comb begin
        w_est_nxt = r_est;
        case (r_est)
            EST_NORMAL: begin
                if (w_any_zero)
                    w_est_nxt = EST_CRITICO;
                else if (w_any_alert)
                    w_est_nxt = EST_ALERTA;
            end
            EST_ALERTA: begin
                if (w_any_zero)
                    w_est_nxt = EST_CRITICO;
                else if (!w_any_alert)
                    w_est_nxt = EST_NORMAL;
            end
            EST_CRITICO: begin
                if (r_dth == DTH_MAX)
                    w_est_nxt = EST_MUERTO;
                else if (!w_any_zero && w_any_alert)
                    w_est_nxt = EST_ALERTA;
                else if (!w_any_alert)
                    w_est_nxt = EST_NORMAL;
            end
            EST_MUERTO: w_est_nxt = EST_MUERTO;
            default:    w_est_nxt = EST_NORMAL;
        endcase
    end

    assign estado       = r_est;
    assign period_pulse = r_pulse;

endmodule

// File: tb/tb_mascota_necesidades_n.sv
// Bench for mascota_necesidades_n: directed vector tables plus randomized run against a reference model.
module tb_mascota_necesidades_n;
    localparam int N_CH = 4, LVL_W = 3, LVL_MAX = 5, LOW_TH = 1;
    localparam int TICK_DIV = 2, DECAY_TICKS = 4, TEST_DIV = 4, INC = 2, DEATH_PERIODS = 2;

    logic        clk = 1'b0;
    logic        reset, test_mode;
    logic [3:0]  evt_in, cond_in;
    logic [11:0] levels;
    logic [3:0]  alert_mask;
    logic [1:0]  worst_ch;
    logic [2:0]  estado;
    logic        period_pulse;

    always #5 clk = ~clk;

    mascota_necesidades_n #(
        .N_CH(N_CH), .LVL_W(LVL_W), .LVL_MAX(LVL_MAX), .LOW_TH(LOW_TH),
        .TICK_DIV(TICK_DIV), .DECAY_TICKS(DECAY_TICKS), .TEST_DIV(TEST_DIV),
        .INC(INC), .DEATH_PERIODS(DEATH_PERIODS)
    ) dut (
        .clk(clk), .reset(reset), .test_mode(test_mode), .evt_in(evt_in),
        .cond_in(cond_in), .levels(levels), .alert_mask(alert_mask),
        .worst_ch(worst_ch), .estado(estado), .period_pulse(period_pulse)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: clock counted in plain integers, status from the rules directly.
    int m_lvl [4];
    int m_pre, m_per, m_dth, m_st;
    bit m_pulse;

    function automatic void model_step(input bit rst, input bit tm,
                                       input logic [3:0] evt, input logic [3:0] cond);
        bit anyz, anya, tick, np;
        int per_len, nper, nd, nst, v;
        if (rst) begin
            foreach (m_lvl[i]) m_lvl[i] = LVL_MAX;
            m_pre = 0; m_per = 0; m_dth = 0; m_st = 0; m_pulse = 0;
            return;
        end
        anyz = 0; anya = 0;
        foreach (m_lvl[i]) begin
            if (m_lvl[i] == 0) anyz = 1;
            if (m_lvl[i] <= LOW_TH) anya = 1;
        end
        tick    = (m_pre == TICK_DIV - 1);
        per_len = tm ? ((DECAY_TICKS / TEST_DIV < 1) ? 1 : DECAY_TICKS / TEST_DIV) : DECAY_TICKS;
        np = 0; nper = m_per;
        if (tick) begin
            if (m_per + 1 >= per_len) begin np = 1; nper = 0; end
            else nper = m_per + 1;
        end
        if (!anyz) nd = 0;
        else if (m_pulse) nd = (m_dth + 1 > DEATH_PERIODS) ? DEATH_PERIODS : m_dth + 1;
        else nd = m_dth;
        if (m_st == 3) nst = 3;
        else if (m_st == 2 && m_dth == DEATH_PERIODS) nst = 3;
        else if (anyz) nst = 2;
        else if (anya) nst = 1;
        else nst = 0;
        if (m_st != 3) begin
            foreach (m_lvl[i]) begin
                v = m_lvl[i] + (evt[i] ? INC : 0) + (m_pulse ? (cond[i] ? 1 : -1) : 0);
                m_lvl[i] = (v < 0) ? 0 : (v > LVL_MAX) ? LVL_MAX : v;
            end
        end
        m_pre   = tick ? 0 : m_pre + 1;
        m_per   = nper;
        m_dth   = nd;
        m_st    = nst;
        m_pulse = np;
    endfunction

    function automatic logic [21:0] model_out();
        logic [11:0] lv;
        logic [3:0]  al;
        int          w, mn;
        w = 0; mn = m_lvl[0];
        for (int i = 0; i < 4; i++) begin
            lv[i*3 +: 3] = 3'(m_lvl[i]);
            al[i]        = (m_lvl[i] <= LOW_TH);
            if (m_lvl[i] < mn) begin mn = m_lvl[i]; w = i; end
        end
        return {lv, al, 2'(w), 3'(m_st), m_pulse};
    endfunction

    task automatic step(input bit rst, input bit tm, input logic [3:0] evt, input logic [3:0] cond);
        logic [21:0] exp_v, got_v;
        reset = rst; test_mode = tm; evt_in = evt; cond_in = cond;
        @(posedge clk);
        model_step(rst, tm, evt, cond);
        #1;
        cyc++;
        exp_v = model_out();
        got_v = {levels, alert_mask, worst_ch, estado, period_pulse};
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL model cyc=%0d got lvl=%o al=%h wc=%0d st=%0d pp=%0d exp lvl=%o al=%h wc=%0d st=%0d pp=%0d",
                     cyc, got_v[21:10], got_v[9:6], got_v[5:4], got_v[3:1], got_v[0],
                     exp_v[21:10], exp_v[9:6], exp_v[5:4], exp_v[3:1], exp_v[0]);
        end
    endtask

    task automatic chk(input string nm, input int got, input int exp_v);
        checks++;
        if (got != exp_v) begin
            errors++;
            $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", nm, got, got, exp_v, exp_v);
        end
    endtask

    typedef struct {
        int          at;
        logic [11:0] lvl;
        logic [3:0]  alert;
        logic [2:0]  est;
        logic        pulse;
    } vec_t;

    vec_t tab_a [9];

    initial begin
        int ti;
        logic       tm_r;
        logic [3:0] cond_r, evt_r;

        tab_a[0] = '{7,  12'o5555, 4'h0, 3'd0, 1'b0};
        tab_a[1] = '{8,  12'o5555, 4'h0, 3'd0, 1'b1};
        tab_a[2] = '{9,  12'o4444, 4'h0, 3'd0, 1'b0};
        tab_a[3] = '{33, 12'o1111, 4'hF, 3'd0, 1'b0};
        tab_a[4] = '{34, 12'o1111, 4'hF, 3'd1, 1'b0};
        tab_a[5] = '{41, 12'o0000, 4'hF, 3'd1, 1'b0};
        tab_a[6] = '{42, 12'o0000, 4'hF, 3'd2, 1'b0};
        tab_a[7] = '{57, 12'o0000, 4'hF, 3'd2, 1'b0};
        tab_a[8] = '{58, 12'o0000, 4'hF, 3'd3, 1'b0};

        reset = 1'b1; test_mode = 1'b0; evt_in = '0; cond_in = '0;

        // reset state
        repeat (3) step(1, 0, 4'h0, 4'h0);
        chk("rst_levels", int'(levels), 12'o5555);
        chk("rst_alert", int'(alert_mask), 0);
        chk("rst_worst", int'(worst_ch), 0);
        chk("rst_estado", int'(estado), 0);
        chk("rst_pulse", int'(period_pulse), 0);

        // free decay all the way to MUERTO
        ti = 0;
        for (int k = 1; k <= 58; k++) begin
            step(0, 0, 4'h0, 4'h0);
            if (ti < 9 && tab_a[ti].at == k) begin
                chk($sformatf("decay_lvl@%0d", k), int'(levels), int'(tab_a[ti].lvl));
                chk($sformatf("decay_alert@%0d", k), int'(alert_mask), int'(tab_a[ti].alert));
                chk($sformatf("decay_est@%0d", k), int'(estado), int'(tab_a[ti].est));
                chk($sformatf("decay_pulse@%0d", k), int'(period_pulse), int'(tab_a[ti].pulse));
                ti++;
            end
        end

        // MUERTO is frozen and sticky until reset
        step(0, 0, 4'hF, 4'hF);
        repeat (2) step(0, 0, 4'h0, 4'hF);
        chk("dead_levels", int'(levels), 0);
        chk("dead_estado", int'(estado), 3);
        step(1, 0, 4'h0, 4'h0);
        chk("revive_levels", int'(levels), 12'o5555);
        chk("revive_estado", int'(estado), 0);

        // event + decay netting, worst channel ties, recovery under cond
        repeat (2) step(1, 0, 4'h0, 4'h0);
        for (int k = 1; k <= 8; k++) step(0, 0, 4'h0, 4'h0);
        step(0, 0, 4'b0010, 4'h0);
        chk("sat_evt_decay_lvl", int'(levels), 12'o4454);
        chk("sat_evt_decay_worst", int'(worst_ch), 0);
        step(0, 0, 4'b1000, 4'h0);
        chk("tie_ch0_ch2_lvl", int'(levels), 12'o5454);
        chk("tie_ch0_ch2_worst", int'(worst_ch), 0);
        step(0, 0, 4'b0001, 4'h0);
        chk("worst_ch2_lvl", int'(levels), 12'o5455);
        chk("worst_ch2", int'(worst_ch), 2);
        for (int k = 12; k <= 25; k++) step(0, 0, 4'h0, 4'h0);
        chk("pre_cond_lvl", int'(levels), 12'o3233);
        for (int k = 26; k <= 33; k++) step(0, 0, 4'h0, 4'b1000);
        chk("cond_p1_lvl", int'(levels), 12'o4122);
        for (int k = 34; k <= 41; k++) step(0, 0, 4'h0, 4'b1000);
        chk("cond_p2_lvl", int'(levels), 12'o5011);
        for (int k = 42; k <= 48; k++) step(0, 0, 4'h0, 4'b1000);
        step(0, 0, 4'b0010, 4'b1000);
        chk("cond_p3_evt_lvl", int'(levels), 12'o5020);
        chk("cond_p3_worst", int'(worst_ch), 0);

        // test mode: one-tick period
        repeat (2) step(1, 0, 4'h0, 4'h0);
        step(0, 1, 4'h0, 4'h0); chk("tm_pulse1", int'(period_pulse), 0);
        step(0, 1, 4'h0, 4'h0); chk("tm_pulse2", int'(period_pulse), 1);
        step(0, 1, 4'h0, 4'h0); chk("tm_pulse3", int'(period_pulse), 0);
        step(0, 1, 4'h0, 4'h0); chk("tm_pulse4", int'(period_pulse), 1);

        // toggle mid-period shortens the current period, levels step by one
        repeat (2) step(1, 0, 4'h0, 4'h0);
        for (int k = 1; k <= 5; k++) step(0, 0, 4'h0, 4'h0);
        chk("tog_pulse5", int'(period_pulse), 0);
        step(0, 1, 4'h0, 4'h0);
        chk("tog_pulse6", int'(period_pulse), 1);
        step(0, 0, 4'h0, 4'h0);
        chk("tog_lvl7", int'(levels), 12'o4444);
        for (int k = 8; k <= 13; k++) step(0, 0, 4'h0, 4'h0);
        chk("tog_pulse13", int'(period_pulse), 0);
        step(0, 0, 4'h0, 4'h0);
        chk("tog_pulse14", int'(period_pulse), 1);
        step(0, 0, 4'h0, 4'h0);
        chk("tog_lvl15", int'(levels), 12'o3333);

        // randomized run against the model
        repeat (2) step(1, 0, 4'h0, 4'h0);
        tm_r = 1'b0; cond_r = 4'h0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 99) == 0) tm_r = ~tm_r;
            if ($urandom_range(0, 31) == 0) cond_r = 4'($urandom);
            evt_r = 4'($urandom & $urandom & $urandom);
            step(($urandom_range(0, 499) == 0), tm_r, evt_r, cond_r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
